alctclctgem_win_decoder: RTL and testbench
==========================================

// Module: alctclctgem_win_decoder
// PURPOSE
//  Consumer end of the CLCT-GEM best-match tree encoder. Takes the 3-bit winner index and the
//  minimum bending angle it produces, and pulls the winning candidate's GEM data back out of
//  a latency-aligned copy of the 8 candidate inputs. Accepted matches are queued in a small
//  FIFO and offered to downstream readout/MPC logic over a valid/ready handshake.
// PARAMETERS
//  DW          14  bits of GEM data per candidate (roll+pad+cluster size)
//  ENC_LAT     1   encoder latency in clocks, from candidate inputs to win_best/pri_best (>=1)
//  FIFO_DEPTH  4   queued matches; power of 2, 2..16
//  CNT_W       8   width of the diagnostic counters
// PORTS
//  clock         in   1       single system clock
//  global_reset  in   1       synchronous, active-high reset
//  match_strobe  in   1       candidate set valid this bx; same cycle as the encoder's win_pri_* inputs
//  cand_valid    in   8       per-candidate GEM match valid, bit i = candidate i
//  cand_data     in   8*DW    candidate i data at [i*DW +: DW]
//  win_best      in   3       encoder winner index (ENC_LAT clocks after match_strobe)
//  pri_best      in   10      encoder minimum bending angle (same cycle as win_best)
//  angle_max     in   10      accept only if pri_best <= angle_max; 10'h3FF accepts all
//  cnt_clear     in   1       synchronous clear of both counters
//  out_valid     out  1       FIFO head valid
//  out_ready     in   1       downstream takes head when out_valid & out_ready
//  out_win       out  3       head winner index
//  out_angle     out  10      head bending angle
//  out_data      out  DW      head GEM data of the winning candidate
//  out_onehot    out  8       head winner as one-hot (1<<out_win)
//  nomatch_cnt   out  CNT_W   strobes rejected (winner invalid or angle > angle_max), saturating
//  drop_cnt      out  CNT_W   accepted matches lost to a full FIFO, saturating
// BEHAVIOUR
//  - Reset: delay line, FIFO pointers and count, and both counters go to 0. out_valid=0,
//    out_* = 0. A reset mid-operation discards all queued and in-flight entries.
//  - Alignment: match_strobe, cand_valid and cand_data pass through an ENC_LAT-deep register
//    shift line. Stage S is the cycle where strobe_d=1, the same cycle as win_best/pri_best.
//  - Stage S, combinational: sel_valid = cand_valid_d[win_best];
//    sel_data = cand_data_d[win_best*DW +: DW];
//    accept = strobe_d & sel_valid & (pri_best <= angle_max), an unsigned 10-bit compare.
//    A strobe_d without accept increments nomatch_cnt. win_best/pri_best are ignored when strobe_d=0.
//  - Push: on accept, record {win,angle,data} is written on the clock edge that ends stage S.
//  - Latency: strobe at T -> stage S at T+ENC_LAT -> out_valid at T+ENC_LAT+1 if the FIFO was empty.
//  - Pop: the head advances on out_valid & out_ready. out_* hold stable while out_valid & !out_ready.
//  - Full: a push with a pop in the same cycle is accepted, and count is unchanged.
//    A push without a pop drops the new record, keeps the existing contents, and increments drop_cnt.
//  - Empty: out_ready is ignored. Push-to-empty is not bypassed, so first visibility is the next cycle.
//  - Counters saturate at 2^CNT_W-1. cnt_clear wins over an increment in the same cycle.
//  - Pointers wrap modulo FIFO_DEPTH. count is CLOG2(FIFO_DEPTH)+1 bits.
//  - Ties: the decoder trusts win_best as given. The encoder picks the lowest index among equals.
// STRUCTURE
//  - Package alctclctgem_pkg: NCAND=8, WIN_W=3, ANGLE_W=10, DW default, REC_W=WIN_W+ANGLE_W+DW,
//    record field offsets.
//  - One sub-module, alctclctgem_win_fifo: synchronous FIFO of REC_W, DEPTH, push/pop/full/empty,
//    write-when-full-with-pop allowed.
//  - Top level holds the delay line, index mux/one-hot decode, accept logic and counters.
// TESTING
//  1. Strobe at T, cand_valid=8'h10, cand4 data=14'h1A5; win=4, angle=12 at T+1, angle_max=3FF
//     -> out_valid at T+2, out_win=4, out_onehot=8'h10, out_data=1A5, out_angle=12.
//  2. Same stimulus but cand_valid=8'h00 -> no out_valid, nomatch_cnt=1.
//     angle=40 with angle_max=39 -> rejected. angle=39 -> accepted.
//  3. out_ready=0, 6 accepted strobes -> 4 queued, drop_cnt=2. Release ready -> 4 pops in order, then out_valid=0.
//  4. FIFO full, with a push and out_ready=1 in the same cycle -> no drop, count stays 4, new record at tail.
//  5. global_reset with 3 entries queued and a strobe in flight -> out_valid=0 and counters 0 on the
//     next cycle; the in-flight strobe produces nothing.
//  6. 300 rejected strobes -> nomatch_cnt=255 (saturated). cnt_clear -> 0.

Source files
------------

// File: rtl/alctclctgem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alctclctgem_pkg
//  Purpose  : Shared widths and record layout for the CLCT-GEM winner decoder.
//             A record is packed as {win, angle, data} with data in the LSBs.
//  Revision : 1.0  initial release
// ============================================================================
package alctclctgem_pkg;

    localparam int NCAND   = 8;
    localparam int WIN_W   = 3;
    localparam int ANGLE_W = 10;
    localparam int DW_DEF  = 14;
    localparam int REC_W   = WIN_W + ANGLE_W + DW_DEF;

    // Field offsets for the default data width
    localparam int DATA_LSB  = 0;
    localparam int ANGLE_LSB = DW_DEF;
    localparam int WIN_LSB   = DW_DEF + ANGLE_W;

    // Layout helpers for a non-default data width
    function automatic int rec_width(input int dw);
        return WIN_W + ANGLE_W + dw;
    endfunction

    function automatic int angle_lsb(input int dw);
        return dw;
    endfunction

    function automatic int win_lsb(input int dw);
        return dw + ANGLE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alctclctgem_win_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : alctclctgem_win_fifo
//  Purpose  : Small synchronous FIFO for accepted match records. A push while
//             full is taken only when a pop happens in the same cycle; the
//             head reads as zero while empty.
//  Revision : 1.0  initial release
// ============================================================================
module alctclctgem_win_fifo
    import alctclctgem_pkg::*;
#(
    parameter int WIDTH = REC_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because the head is gated by empty
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alctclctgem_win_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alctclctgem_win_decoder
//  Purpose  : Consumer of the CLCT-GEM best-match encoder. Aligns the candidate
//             inputs to the encoder result, selects the winner's GEM data,
//             filters on bending angle, and queues accepted matches for a
//             valid/ready downstream. Counts rejected strobes and drops.
//  Revision : 1.0  initial release
// ============================================================================
module alctclctgem_win_decoder
    import alctclctgem_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int ENC_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                  clock,
    input  logic                  global_reset,
    input  logic                  match_strobe,
    input  logic [NCAND-1:0]      cand_valid,
    input  logic [NCAND*DW-1:0]   cand_data,
    input  logic [WIN_W-1:0]      win_best,
    input  logic [ANGLE_W-1:0]    pri_best,
    input  logic [ANGLE_W-1:0]    angle_max,
    input  logic                  cnt_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIN_W-1:0]      out_win,
    output logic [ANGLE_W-1:0]    out_angle,
    output logic [DW-1:0]         out_data,
    output logic [NCAND-1:0]      out_onehot,
    output logic [CNT_W-1:0]      nomatch_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int RW     = rec_width(DW);
    localparam int A_LSB  = angle_lsb(DW);
    localparam int W_LSB  = win_lsb(DW);

    // Delay line bringing the candidate set into step with win_best/pri_best
    logic                r_strobe_d [ENC_LAT];
    logic [NCAND-1:0]    r_valid_d  [ENC_LAT];
    logic [NCAND*DW-1:0] r_data_d   [ENC_LAT];

    logic                w_strobe_s;
    logic [NCAND-1:0]    w_valid_s;
    logic [NCAND*DW-1:0] w_data_s;
    logic                w_sel_valid;
    logic [DW-1:0]       w_sel_data;
    logic                w_accept;
    logic                w_reject;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [RW-1:0]       w_push_rec;
    logic [RW-1:0]       w_head;

    // Shift the strobe and candidate set ENC_LAT stages
    always_ff @(posedge clock) begin
        if (global_reset) begin
            for (int i = 0; i < ENC_LAT; i++) begin
                r_strobe_d[i] <= 1'b0;
                r_valid_d[i]  <= '0;
                r_data_d[i]   <= '0;
            end
        end else begin
            r_strobe_d[0] <= match_strobe;
            r_valid_d[0]  <= cand_valid;
            r_data_d[0]   <= cand_data;
            for (int i = 1; i < ENC_LAT; i++) begin
                r_strobe_d[i] <= r_strobe_d[i-1];
                r_valid_d[i]  <= r_valid_d[i-1];
                r_data_d[i]   <= r_data_d[i-1];
            end
        end
    end

    assign w_strobe_s  = r_strobe_d[ENC_LAT-1];
    assign w_valid_s   = r_valid_d[ENC_LAT-1];
    assign w_data_s    = r_data_d[ENC_LAT-1];

    // Winner selection trusts win_best as given; tie-breaking is the encoder's job
    assign w_sel_valid = w_valid_s[win_best];
    assign w_sel_data  = w_data_s[win_best*DW +: DW];
    assign w_accept    = w_strobe_s & w_sel_valid & (pri_best <= angle_max);
    assign w_reject    = w_strobe_s & ~w_accept;
    assign w_push_rec  = {win_best, pri_best, w_sel_data};

    assign w_pop       = out_valid & out_ready;
    assign w_drop      = w_accept & w_full & ~w_pop;

    alctclctgem_win_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst       (global_reset),
        .push      (w_accept),
        .push_data (w_push_rec),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    // The FIFO zeroes its head while empty, so the fields need no extra gating
    assign out_valid  = ~w_empty;
    assign out_win    = w_head[W_LSB +: WIN_W];
    assign out_angle  = w_head[A_LSB +: ANGLE_W];
    assign out_data   = w_head[0 +: DW];
    assign out_onehot = out_valid ? (NCAND'(1) << out_win) : '0;

    // Rejected-strobe counter: saturating, clear has priority over increment
    always_ff @(posedge clock) begin
        if (global_reset || cnt_clear) begin
            nomatch_cnt <= '0;
        end else if (w_reject && (nomatch_cnt != '1)) begin
            nomatch_cnt <= nomatch_cnt + CNT_W'(1);
        end
    end

    // Full-FIFO drop counter: saturating, clear has priority over increment
    always_ff @(posedge clock) begin
        if (global_reset || cnt_clear) begin
            drop_cnt <= '0;
        end else if (w_drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alctclctgem_win_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alctclctgem_win_decoder
//  Purpose  : Directed, table-driven bench for the CLCT-GEM winner decoder
//             with hand sequences for queueing, full, reset and saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alctclctgem_win_decoder;

    localparam int DW = 14;

    logic           clock = 1'b0;
    logic           global_reset;
    logic           match_strobe;
    logic [7:0]     cand_valid;
    logic [8*DW-1:0] cand_data;
    logic [2:0]     win_best;
    logic [9:0]     pri_best;
    logic [9:0]     angle_max;
    logic           cnt_clear;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     out_win;
    logic [9:0]     out_angle;
    logic [DW-1:0]  out_data;
    logic [7:0]     out_onehot;
    logic [7:0]     nomatch_cnt;
    logic [7:0]     drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    alctclctgem_win_decoder #(
        .DW         (DW),
        .ENC_LAT    (1),
        .FIFO_DEPTH (4),
        .CNT_W      (8)
    ) dut (
        .clock        (clock),
        .global_reset (global_reset),
        .match_strobe (match_strobe),
        .cand_valid   (cand_valid),
        .cand_data    (cand_data),
        .win_best     (win_best),
        .pri_best     (pri_best),
        .angle_max    (angle_max),
        .cnt_clear    (cnt_clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_win      (out_win),
        .out_angle    (out_angle),
        .out_data     (out_data),
        .out_onehot   (out_onehot),
        .nomatch_cnt  (nomatch_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  cv;
        logic [2:0]  win;
        logic [9:0]  ang;
        logic [9:0]  amax;
        logic [13:0] wd;
        logic        acc;
    } vec_t;

    vec_t tbl [8];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        global_reset = 1'b1;
        step();
        step();
        global_reset = 1'b0;
    endtask

    // Strobe cycle then encoder-result cycle; outputs are visible on return
    task automatic issue(input logic [7:0] cv, input logic [2:0] w, input logic [9:0] ang,
                         input logic [9:0] amax, input logic [13:0] wd, input logic rdy_s,
                         input logic chk_lat);
        logic [8*DW-1:0] d;
        for (int i = 0; i < 8; i++) begin
            d[i*DW +: DW] = (i == int'(w)) ? wd : (14'h3FFF ^ 14'(i * 37));
        end
        match_strobe = 1'b1;
        cand_valid   = cv;
        cand_data    = d;
        angle_max    = amax;
        step();
        match_strobe = 1'b0;
        cand_valid   = '0;
        cand_data    = '0;
        win_best     = w;
        pri_best     = ang;
        out_ready    = rdy_s;
        if (chk_lat) chk("latency_pre", {31'd0, out_valid}, 32'd0);
        step();
        win_best  = '0;
        pri_best  = '0;
        out_ready = 1'b0;
    endtask

    logic [13:0] exp_d [6];
    int exp_nm;

    initial begin
        global_reset = 1'b1;
        match_strobe = 1'b0;
        cand_valid   = '0;
        cand_data    = '0;
        win_best     = '0;
        pri_best     = '0;
        angle_max    = 10'h3FF;
        cnt_clear    = 1'b0;
        out_ready    = 1'b0;

        tbl[0] = '{cv: 8'h10, win: 3'd4, ang: 10'd12,  amax: 10'h3FF, wd: 14'h1A5,  acc: 1'b1};
        tbl[1] = '{cv: 8'h00, win: 3'd4, ang: 10'd12,  amax: 10'h3FF, wd: 14'h1A5,  acc: 1'b0};
        tbl[2] = '{cv: 8'hFF, win: 3'd2, ang: 10'd40,  amax: 10'd39,   wd: 14'h2ABC, acc: 1'b0};
        tbl[3] = '{cv: 8'hFF, win: 3'd2, ang: 10'd39,  amax: 10'd39,   wd: 14'h2ABC, acc: 1'b1};
        tbl[4] = '{cv: 8'h01, win: 3'd0, ang: 10'd0,   amax: 10'd0,    wd: 14'h0001, acc: 1'b1};
        tbl[5] = '{cv: 8'h80, win: 3'd7, ang: 10'h3FF, amax: 10'h3FF,  wd: 14'h3FFE, acc: 1'b1};
        tbl[6] = '{cv: 8'h7F, win: 3'd7, ang: 10'd5,   amax: 10'h3FF,  wd: 14'h1234, acc: 1'b0};
        tbl[7] = '{cv: 8'hFF, win: 3'd5, ang: 10'h3FF, amax: 10'h3FE,  wd: 14'h0F0F, acc: 1'b0};

        step();
        step();
        global_reset = 1'b0;

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {18'd0, out_data}, 32'd0);
        chk("rst_out_onehot", {24'd0, out_onehot}, 32'd0);
        chk("rst_nomatch", {24'd0, nomatch_cnt}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);

        // Table-driven accept/reject vectors, one at a time
        exp_nm = 0;
        for (int v = 0; v < 8; v++) begin
            issue(tbl[v].cv, tbl[v].win, tbl[v].ang, tbl[v].amax, tbl[v].wd, 1'b0, 1'b1);
            if (!tbl[v].acc) exp_nm++;
            chk($sformatf("vec%0d_valid", v), {31'd0, out_valid}, {31'd0, tbl[v].acc});
            chk($sformatf("vec%0d_nomatch", v), {24'd0, nomatch_cnt}, 32'(exp_nm));
            if (tbl[v].acc) begin
                chk($sformatf("vec%0d_win", v), {29'd0, out_win}, {29'd0, tbl[v].win});
                chk($sformatf("vec%0d_angle", v), {22'd0, out_angle}, {22'd0, tbl[v].ang});
                chk($sformatf("vec%0d_data", v), {18'd0, out_data}, {18'd0, tbl[v].wd});
                chk($sformatf("vec%0d_onehot", v), {24'd0, out_onehot}, 32'd1 << tbl[v].win);
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                chk($sformatf("vec%0d_popped", v), {31'd0, out_valid}, 32'd0);
            end
        end

        // Six accepted strobes with the consumer stalled: four queued, two dropped
        do_reset();
        for (int k = 0; k < 6; k++) begin
            exp_d[k] = 14'h100 + 14'(k);
            issue(8'hFF, 3'(k), 10'(k), 10'h3FF, exp_d[k], 1'b0, 1'b0);
        end
        step();
        chk("full_head_hold", {18'd0, out_data}, {18'd0, exp_d[0]});
        chk("full_drop_cnt", {24'd0, drop_cnt}, 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("drain%0d_data", k), {18'd0, out_data}, {18'd0, exp_d[k]});
            chk($sformatf("drain%0d_win", k), {29'd0, out_win}, 32'(k));
            step();
        end
        chk("drain_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Push into a full FIFO with a same-cycle pop: no drop, new record at tail
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_d[k] = 14'h200 + 14'(k);
            issue(8'hFF, 3'(k), 10'd1, 10'h3FF, exp_d[k], 1'b0, 1'b0);
        end
        exp_d[4] = 14'h2F0;
        issue(8'hFF, 3'd6, 10'd2, 10'h3FF, exp_d[4], 1'b1, 1'b0);
        chk("pushpop_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("pp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("pp%0d_data", k), {18'd0, out_data}, {18'd0, exp_d[k]});
            step();
        end
        chk("pushpop_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset with three entries queued and a strobe in flight
        do_reset();
        issue(8'h00, 3'd1, 10'd1, 10'h3FF, 14'h0AA, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            issue(8'hFF, 3'(k), 10'd3, 10'h3FF, 14'h300 + 14'(k), 1'b0, 1'b0);
        end
        chk("pre_rst_nomatch", {24'd0, nomatch_cnt}, 32'd1);
        match_strobe = 1'b1;
        cand_valid   = 8'hFF;
        cand_data    = {8{14'h155}};
        step();
        match_strobe = 1'b0;
        cand_valid   = '0;
        win_best     = 3'd3;
        pri_best     = 10'd3;
        global_reset = 1'b1;
        step();
        global_reset = 1'b0;
        win_best     = '0;
        pri_best     = '0;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_nomatch", {24'd0, nomatch_cnt}, 32'd0);
        chk("midrst_data", {18'd0, out_data}, 32'd0);
        step();
        step();
        chk("midrst_inflight", {31'd0, out_valid}, 32'd0);

        // 300 back-to-back rejected strobes saturate, clear wins over increment
        do_reset();
        cand_valid = 8'h00;
        match_strobe = 1'b1;
        for (int k = 0; k < 300; k++) step();
        chk("sat_nomatch", {24'd0, nomatch_cnt}, 32'd255);
        match_strobe = 1'b0;
        cnt_clear    = 1'b1;
        step();
        cnt_clear    = 1'b0;
        chk("clear_nomatch", {24'd0, nomatch_cnt}, 32'd0);
        step();
        chk("clear_hold", {24'd0, nomatch_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
